// File: rtl/ddf_pkg.sv
// Shared helpers for the multi-flux PICK actor: token field extraction,
// selector width and the flattened (port, flux) bus index.
package ddf_pkg;

    function automatic int unsigned sel_width(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic int unsigned flat_idx(input int unsigned p, input int unsigned f,
                                             input int unsigned flux);
        return p * flux + f;
    endfunction

    function automatic logic [31:0] tag_of(input logic [63:0] tok, input int unsigned dw,
                                           input int unsigned tw);
        return 32'((tok >> dw) & ((64'd1 << tw) - 64'd1));
    endfunction

    // Low-order field of a token; also used to pull the selector out of a control payload.
    function automatic logic [63:0] payload_of(input logic [63:0] tok, input int unsigned dw);
        return tok & ((64'd1 << dw) - 64'd1);
    endfunction

endpackage

// File: rtl/ddf_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when the same cycle pops.
module ddf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddf_pick_mflux.sv
// Multi-flux dynamic-dataflow PICK: per-flux control tokens choose which data
// port supplies the next token; ready fluxes share the output round-robin.
module ddf_pick_mflux
    import ddf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int PORTS      = 2,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = $clog2(FLUX),
    parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       in_port_write,
    input  logic [PORTS*WIDTH-1:0] in_port_datain,
    output logic [PORTS*FLUX-1:0]  in_port_full,
    input  logic                   in_port_write_nda,
    input  logic [WIDTH-1:0]       in_port_datain_nda,
    output logic [FLUX-1:0]        in_port_full_nda,
    input  logic                   out_port_full,
    output logic                   out_port_write,
    output logic [WIDTH-1:0]       out_port_dataout,
    output logic                   err_sel
);
    localparam int SW = int'(sel_width(PORTS));
    localparam int NQ = PORTS * FLUX;

    logic [NQ-1:0]         d_push, d_pop, d_full, d_empty;
    logic [DATA_WIDTH-1:0] d_dout [NQ];
    logic [FLUX-1:0]       c_push, c_pop, c_full, c_empty;
    logic [DATA_WIDTH-1:0] c_dout [FLUX];
    logic [DATA_WIDTH-1:0] port_pay [PORTS];
    logic [DATA_WIDTH-1:0] nda_pay;

    logic [SW-1:0]         sel [FLUX];
    logic [FLUX-1:0]       sel_ok, ready, bad;
    logic [TAG_WIDTH-1:0]  rr, win, cand;
    logic                  fire;

    assign nda_pay          = DATA_WIDTH'(payload_of(64'(in_port_datain_nda), DATA_WIDTH));
    assign in_port_full     = d_full;
    assign in_port_full_nda = c_full;

    // Route incoming tokens by tag; tags >= FLUX match no FIFO and are dropped.
    always_comb begin
        d_push = '0;
        c_push = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int f = 0; f < FLUX; f++) begin
                if (in_port_write[p] &&
                    tag_of(64'(in_port_datain[p*WIDTH +: WIDTH]), DATA_WIDTH, TAG_WIDTH) == 32'(f))
                    d_push[flat_idx(p, f, FLUX)] = 1'b1;
            end
        end
        for (int f = 0; f < FLUX; f++) begin
            if (in_port_write_nda &&
                tag_of(64'(in_port_datain_nda), DATA_WIDTH, TAG_WIDTH) == 32'(f))
                c_push[f] = 1'b1;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        assign port_pay[p] = DATA_WIDTH'(payload_of(64'(in_port_datain[p*WIDTH +: WIDTH]), DATA_WIDTH));
        for (genvar f = 0; f < FLUX; f++) begin : g_flux
            localparam int Q = int'(flat_idx(p, f, FLUX));
            ddf_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_dfifo (
                .clk   (clk),
                .rst   (rst),
                .push  (d_push[Q]),
                .pop   (d_pop[Q]),
                .din   (port_pay[p]),
                .full  (d_full[Q]),
                .empty (d_empty[Q]),
                .dout  (d_dout[Q])
            );
        end
    end

    for (genvar f = 0; f < FLUX; f++) begin : g_ctrl
        ddf_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_cfifo (
            .clk   (clk),
            .rst   (rst),
            .push  (c_push[f]),
            .pop   (c_pop[f]),
            .din   (nda_pay),
            .full  (c_full[f]),
            .empty (c_empty[f]),
            .dout  (c_dout[f])
        );
        assign sel[f]    = SW'(payload_of(64'(c_dout[f]), SW));
        assign sel_ok[f] = 32'(sel[f]) < 32'(PORTS);
        assign ready[f]  = !c_empty[f] && sel_ok[f] && !out_port_full &&
                           !d_empty[flat_idx(sel_ok[f] ? 32'(sel[f]) : 32'd0, f, FLUX)];
        assign bad[f]    = !c_empty[f] && !sel_ok[f] && !out_port_full;
    end

    // Decision stage: first ready flux at or after rr wins; bad selectors drain in parallel.
    always_comb begin
        fire  = 1'b0;
        win   = '0;
        cand  = '0;
        d_pop = '0;
        c_pop = bad;
        for (int i = 0; i < FLUX; i++) begin
            cand = TAG_WIDTH'((int'(rr) + i) % FLUX);
            if (!fire && ready[cand]) begin
                fire = 1'b1;
                win  = cand;
            end
        end
        if (fire) begin
            c_pop[win] = 1'b1;
            d_pop[flat_idx(32'(sel[win]), 32'(win), FLUX)] = 1'b1;
        end
    end

    // Output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            rr               <= '0;
            out_port_write   <= 1'b0;
            out_port_dataout <= '0;
            err_sel          <= 1'b0;
        end else begin
            out_port_write <= fire;
            if (fire) begin
                out_port_dataout <= {win, d_dout[flat_idx(32'(sel[win]), 32'(win), FLUX)]};
                rr               <= TAG_WIDTH'((int'(win) + 1) % FLUX);
            end
            if (|bad) err_sel <= 1'b1;
        end
    end

endmodule

// File: doc/ddf_pick_mflux.md
Name: ddf_pick_mflux

Overview:
- Parametrised multi-flux dynamic-dataflow PICK actor with integrated input buffering.
- Successor to the fixed 2-port / 2-flux DDF wrapper: PORTS data inputs and FLUX tagged fluxes, each a generic parameter.
- A control input, the non-deterministic-arrival (NDA) stream, selects per flux which data port the next token comes from.
- Sits between producer actors and the downstream consumer in the multi_dataflow fabric; one firing per cycle, fluxes arbitrated round-robin.

Parameters:
- DATA_WIDTH, 8, payload bits per token.
- FLUX, 2, number of interleaved fluxes; must be >= 2.
- PORTS, 2, number of data input ports; must be >= 2.
- DEPTH, 4, per-flux FIFO depth; power of 2, >= 2.
- TAG_WIDTH, $clog2(FLUX), derived; tag carried in the token MSBs.
- WIDTH, DATA_WIDTH+TAG_WIDTH, derived; full token width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_port_write  in  PORTS  per-port write strobe.
- in_port_datain  in  PORTS*WIDTH  port p occupies bits [p*WIDTH +: WIDTH]; token = {tag, payload}.
- in_port_full  out  PORTS*FLUX  bit p*FLUX+f means FIFO(p,f) is full.
- in_port_write_nda  in  1  control token write strobe.
- in_port_datain_nda  in  WIDTH  control token {tag, payload}.
- in_port_full_nda  out  FLUX  bit f means control FIFO f is full.
- out_port_full  in  1  downstream backpressure.
- out_port_write  out  1  output token valid, one-cycle strobe per token.
- out_port_dataout  out  WIDTH  output token {tag, payload}.
- err_sel  out  1  sticky flag: an out-of-range selector was seen.

Behaviour:
- Storage
  - One FIFO per (port, flux) for data, plus one control FIFO per flux.
  - Incoming tokens are routed by their tag field to the FIFO of that flux.
  - A tag value >= FLUX: token dropped.
  - Write to a full FIFO: token dropped, FIFO contents unchanged.
  - Full flags are combinational from the FIFO counts.
- Selector
  - sel = control payload[$clog2(PORTS)-1:0].
  - sel >= PORTS (non-power-of-2 PORTS only): the control token is popped and discarded, err_sel is set, nothing is output for it.
- Firing rule for flux f (ready_f), all conditions required:
  - control FIFO f is non-empty;
  - sel is in range;
  - data FIFO(sel,f) is non-empty;
  - out_port_full is 0.
- Arbitration
  - Round-robin pointer rr (reset 0).
  - The winner is the first ready flux searching from rr upward with wrap-around.
  - On a firing, rr becomes winner+1 mod FLUX.
  - No firing: rr holds.
- Firing, all on the same clock edge:
  - pop control FIFO f and data FIFO(sel,f);
  - out_port_dataout <= {f, data payload};
  - out_port_write <= 1.
  - Cycles with no firing: out_port_write <= 0 and out_port_dataout holds its last value.
- Latency
  - A data token is written at edge k; its FIFO is non-empty at k.
  - The firing decision is taken in the following cycle.
  - out_port_write goes high after edge k+1.
  - Minimum latency is 1 cycle after the last required token is written.
- Backpressure
  - out_port_full is sampled in the decision cycle.
  - While it is high, no pops occur and all FIFOs hold their contents.
- Simultaneous events
  - Push and pop on the same FIFO in the same cycle are both performed; the count is unchanged.
  - A push to a full FIFO during a pop of it is accepted, because full is evaluated before the pop.
- Reset
  - Effective at the next edge, including mid-operation.
  - All FIFO pointers and counts go to 0 and contents are discarded.
  - rr = 0, out_port_write = 0, out_port_dataout = 0, err_sel = 0.
  - in_port_full and in_port_full_nda read all zeros.
- Ordering guarantees
  - Per-flux output order equals control-token order.
  - Fluxes are independent: a stalled flux never blocks another ready flux.

Decomposition:
- Package ddf_pkg holds:
  - tag/payload field-extract functions;
  - the selector width function;
  - the flattened-bus index helper (p*FLUX+f).
- Sub-module ddf_sync_fifo:
  - single-clock FIFO, parameters WIDTH and DEPTH;
  - signals push/pop/full/empty/dout, synchronous active-high rst;
  - instantiated via generate: PORTS*FLUX data FIFOs plus FLUX control FIFOs.

Test Plan (FLUX=2, PORTS=2, DATA_WIDTH=8, DEPTH=4):
- Basic pick: control {0,8'd1} plus port1 data {0,8'd7} -> out {0,8'd7} one cycle later, exactly one strobe; FIFO(0,0) is untouched.
- Flux interleave: control {0,0},{1,1}; port0 {0,8'h11}; port1 {1,8'h22}, all ready in the same cycle -> output {0,11} then {1,22}; rr toggles.
- Backpressure: hold out_port_full=1 for 5 cycles with 4 tokens queued -> no strobes; release -> 4 consecutive strobes, in order.
- Full/drop: 5 writes of flux 1 to port0 -> in_port_full bit 1 goes high after the 4th write; the 5th is dropped; later only 4 tokens are output.
- Starvation isolation: flux 0 has control but no data, flux 1 is fully supplied -> flux 1 outputs every cycle, flux 0 outputs nothing.
- Reset mid-stream: assert rst with 3 tokens queued -> next cycle all full flags are 0 and out_port_write is 0; no stale tokens are output afterwards.
- PORTS=3 variant: control selector value 3 -> token dropped, err_sel=1, no output.
